// File: rtl/tristate_bus_arbiter_pkg.sv
// tsb_pkg: shared FSM state type and one-hot helper for tristate_bus_arbiter
package tsb_pkg;
    localparam int MAX_N = 16;
    typedef enum logic [1:0] {IDLE, OWN, TURN} state_t;
    function automatic logic [MAX_N-1:0] onehot(input int idx);
        return MAX_N'(1) << idx;
    endfunction
endpackage

// File: rtl/tristate_bus_arbiter_if.sv
// tristate_bus_arbiter_if: request/grant bundle between requesters and the bus arbiter
// master: arbiter side (req in; grant, drive_en, owner_id, bus_busy out); slave: requester side
interface tristate_bus_arbiter_if #(
    parameter int N = 4
);
    logic [N-1:0] req;
    logic [N-1:0] grant;
    logic [N-1:0] drive_en;
    logic [$clog2(N)-1:0] owner_id;
    logic bus_busy;
    modport master(input req, output grant, drive_en, owner_id, bus_busy);
    modport slave(output req, input grant, drive_en, owner_id, bus_busy);
endinterface

// File: rtl/tristate_bus_arbiter_rr_pick.sv
// rr_pick: combinational round-robin search, i_req/i_start in, o_valid/o_idx out
module rr_pick #(
    parameter int N = 4
) (
    input  logic [N-1:0]         i_req,
    input  logic [$clog2(N)-1:0] i_start,
    output logic                 o_valid,
    output logic [$clog2(N)-1:0] o_idx
);
    localparam int IW = $clog2(N);
    // Walk offsets from farthest to nearest so the nearest set bit is written last.
    always_comb begin
        o_valid = 1'b0;
        o_idx = '0;
        for (int k = N - 1; k >= 0; k--) begin
            if (i_req[(int'(i_start) + k) % N]) begin
                o_valid = 1'b1;
                o_idx = IW'((int'(i_start) + k) % N);
            end
        end
    end
endmodule

// File: rtl/tristate_bus_arbiter.sv
// tristate_bus_arbiter: round-robin bus owner sequencer with turnaround gaps between owners
// Ports: clk, rst (sync active-high); bus (master modport): req in; grant, drive_en, owner_id, bus_busy out
// Macro TSB_PARK_EN: keep the last owner's buffer enabled while idle so the bus never floats
module tristate_bus_arbiter
    import tsb_pkg::*;
#(
    parameter int N = 4,
    parameter int MAX_HOLD = 8,
    parameter int TURN_CYC = 1
) (
    input logic clk,
    input logic rst,
    tristate_bus_arbiter_if.master bus
);
    localparam int IW = $clog2(N);
    localparam int HW = (MAX_HOLD > 0) ? $clog2(MAX_HOLD + 1) : 1;
    localparam int TW = $clog2(TURN_CYC + 1);
    localparam int HOLD_LAST = (MAX_HOLD > 0) ? MAX_HOLD - 1 : 0;
    state_t r_state;
    logic [N-1:0] r_grant, r_drive;
    logic [IW-1:0] r_owner, w_start, w_win;
    logic [HW-1:0] r_hold;
    logic [TW-1:0] r_turn;
    logic r_busy, w_valid, w_force;
    // Search starts just past the current/last owner, so that owner has lowest priority.
    assign w_start = (r_owner == IW'(N - 1)) ? '0 : r_owner + IW'(1);
    assign w_force = (MAX_HOLD > 0) && (r_hold == HW'(HOLD_LAST));
    rr_pick #(.N(N)) u_pick (
        .i_req(bus.req),
        .i_start(w_start),
        .o_valid(w_valid),
        .o_idx(w_win)
    );
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_grant <= '0;
            r_drive <= '0;
            r_owner <= IW'(N - 1);
            r_busy <= 1'b0;
            r_hold <= '0;
            r_turn <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_valid) begin
                        r_busy <= 1'b1;
`ifdef TSB_PARK_EN
                        // A parked buffer must be dropped for a full turnaround before another owner drives.
                        if (r_drive != '0 && w_win != r_owner) begin
                            r_state <= TURN;
                            r_drive <= '0;
                            r_turn <= '0;
                        end else begin
                            r_state <= OWN;
                            r_grant <= N'(onehot(int'(w_win)));
                            r_drive <= N'(onehot(int'(w_win)));
                            r_owner <= w_win;
                            r_hold <= '0;
                        end
`else
                        r_state <= OWN;
                        r_grant <= N'(onehot(int'(w_win)));
                        r_drive <= N'(onehot(int'(w_win)));
                        r_owner <= w_win;
                        r_hold <= '0;
`endif
                    end
                end
                OWN: begin
                    if (!bus.req[r_owner] || w_force) begin
                        r_state <= TURN;
                        r_grant <= '0;
                        r_drive <= '0;
                        r_turn <= '0;
                    end else if (r_hold != '1) begin
                        r_hold <= r_hold + HW'(1);
                    end
                end
                TURN: begin
                    if (r_turn == TW'(TURN_CYC - 1)) begin
                        if (w_valid) begin
                            r_state <= OWN;
                            r_grant <= N'(onehot(int'(w_win)));
                            r_drive <= N'(onehot(int'(w_win)));
                            r_owner <= w_win;
                            r_hold <= '0;
                        end else begin
                            r_state <= IDLE;
                            r_busy <= 1'b0;
`ifdef TSB_PARK_EN
                            r_drive <= N'(onehot(int'(r_owner)));
`endif
                        end
                    end else begin
                        r_turn <= r_turn + TW'(1);
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end
    assign bus.grant = r_grant;
    assign bus.drive_en = r_drive;
    assign bus.owner_id = r_owner;
    assign bus.bus_busy = r_busy;
endmodule

// File: tb/tb_tristate_bus_arbiter.sv
// tb_tristate_bus_arbiter: directed and randomized checks of tristate_bus_arbiter against a behavioural model
module tb_tristate_bus_arbiter;
    localparam int N = 4;
    localparam int MAX_HOLD = 8;
    localparam int TURN_CYC = 1;
    localparam int IW = $clog2(N);
`ifdef TSB_PARK_EN
    localparam bit PARK = 1'b1;
`else
    localparam bit PARK = 1'b0;
`endif
    logic clk = 1'b0;
    logic rst = 1'b1;
    int n_err = 0;
    int n_checks = 0;
    tristate_bus_arbiter_if #(.N(N)) bus ();
    tristate_bus_arbiter #(.N(N), .MAX_HOLD(MAX_HOLD), .TURN_CYC(TURN_CYC)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );
    always #5 clk = ~clk;
    // Model: who owns the bus, how long they have held it, and how many idle gap cycles remain.
    int m_own = -1;
    int m_last = N - 1;
    int m_gap = 0;
    int m_held = 0;
    bit m_parked = 1'b0;
    int w;
    logic [N-1:0] exp_grant, exp_drive;
    logic [IW-1:0] exp_owner;
    logic exp_busy;
    function automatic int pick(logic [N-1:0] r, int last);
        for (int k = 1; k <= N; k++) if (r[(last + k) % N]) return (last + k) % N;
        return -1;
    endfunction
    always @(posedge clk) begin
        if (rst) begin
            m_own = -1;
            m_last = N - 1;
            m_gap = 0;
            m_held = 0;
            m_parked = 1'b0;
        end else if (m_own >= 0) begin
            m_held++;
            if (!bus.req[m_own] || (MAX_HOLD != 0 && m_held == MAX_HOLD)) begin
                m_own = -1;
                m_gap = TURN_CYC;
            end
        end else begin
            w = pick(bus.req, m_last);
            if (m_gap > 0) begin
                m_gap--;
                if (m_gap == 0 && w >= 0) begin
                    m_own = w; m_last = w; m_held = 0; m_parked = 1'b1;
                end
            end else if (w >= 0) begin
                if (PARK && m_parked && w != m_last) m_gap = TURN_CYC;
                else begin
                    m_own = w; m_last = w; m_held = 0; m_parked = 1'b1;
                end
            end
        end
        exp_busy = (m_own >= 0) || (m_gap > 0);
        exp_grant = (m_own >= 0) ? N'(1) << m_own : '0;
        exp_drive = (!exp_busy && PARK && m_parked) ? N'(1) << m_last : exp_grant;
        exp_owner = IW'(m_last);
    end
    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        bus.req = '0;
        @(negedge clk);
        rst = 1'b0;
    endtask
    task automatic test_reset();
        do_reset();
        @(posedge clk); #1;
        n_checks++; if (bus.grant !== 4'b0000) begin n_err++; $display("FAIL reset grant: got %b want 0000", bus.grant); end
        n_checks++; if (bus.drive_en !== 4'b0000) begin n_err++; $display("FAIL reset drive_en: got %b want 0000", bus.drive_en); end
        n_checks++; if (bus.owner_id !== 2'd3) begin n_err++; $display("FAIL reset owner_id: got %0d want 3", bus.owner_id); end
        n_checks++; if (bus.bus_busy !== 1'b0) begin n_err++; $display("FAIL reset bus_busy: got %b want 0", bus.bus_busy); end
    endtask
    task automatic test_reset_in_own();
        do_reset();
        @(negedge clk) bus.req = 4'b0100;
        @(posedge clk); #1;
        n_checks++; if (bus.grant !== 4'b0100) begin n_err++; $display("FAIL own_before_rst grant: got %b want 0100", bus.grant); end
        @(negedge clk) rst = 1'b1;
        @(posedge clk); #1;
        n_checks++; if (bus.grant !== 4'b0000) begin n_err++; $display("FAIL rst_in_own grant: got %b want 0000", bus.grant); end
        n_checks++; if (bus.drive_en !== 4'b0000) begin n_err++; $display("FAIL rst_in_own drive_en: got %b want 0000", bus.drive_en); end
        n_checks++; if (bus.owner_id !== 2'd3) begin n_err++; $display("FAIL rst_in_own owner_id: got %0d want 3", bus.owner_id); end
        n_checks++; if (bus.bus_busy !== 1'b0) begin n_err++; $display("FAIL rst_in_own bus_busy: got %b want 0", bus.bus_busy); end
        @(negedge clk) begin rst = 1'b0; bus.req = '0; end
    endtask
    task automatic test_single();
        do_reset();
        @(negedge clk) bus.req = 4'b0001;
        for (int c = 0; c < 3; c++) begin
            @(posedge clk); #1;
            n_checks++; if (bus.grant !== 4'b0001) begin n_err++; $display("FAIL single grant c%0d: got %b want 0001", c, bus.grant); end
            n_checks++; if (bus.drive_en !== 4'b0001) begin n_err++; $display("FAIL single drive_en c%0d: got %b want 0001", c, bus.drive_en); end
        end
        n_checks++; if (bus.owner_id !== 2'd0) begin n_err++; $display("FAIL single owner_id: got %0d want 0", bus.owner_id); end
        @(negedge clk) bus.req = '0;
        @(posedge clk); #1;
        n_checks++; if (bus.drive_en !== 4'b0000 || bus.bus_busy !== 1'b1) begin n_err++; $display("FAIL single turn: got drive_en=%b busy=%b want 0000/1", bus.drive_en, bus.bus_busy); end
        @(posedge clk); #1;
        n_checks++; if (bus.bus_busy !== 1'b0 || bus.grant !== 4'b0000) begin n_err++; $display("FAIL single idle: got busy=%b grant=%b want 0/0000", bus.bus_busy, bus.grant); end
    endtask
    // With all requests held, each owner gets MAX_HOLD cycles then one turnaround cycle.
    task automatic test_simultaneous();
        logic [N-1:0] want;
        do_reset();
        @(negedge clk) bus.req = 4'b1111;
        for (int c = 0; c < 4 * (MAX_HOLD + TURN_CYC); c++) begin
            @(posedge clk); #1;
            want = (c % (MAX_HOLD + TURN_CYC) < MAX_HOLD) ? N'(1) << (c / (MAX_HOLD + TURN_CYC)) : '0;
            n_checks++; if (bus.grant !== want || bus.drive_en !== want) begin n_err++; $display("FAIL simul c%0d: got grant=%b drive_en=%b want %b", c, bus.grant, bus.drive_en, want); end
            n_checks++; if (bus.bus_busy !== 1'b1) begin n_err++; $display("FAIL simul busy c%0d: got %b want 1", c, bus.bus_busy); end
        end
        @(negedge clk) bus.req = '0;
    endtask
    task automatic test_forced_release();
        logic [N-1:0] want;
        do_reset();
        @(negedge clk) bus.req = 4'b0010;
        for (int c = 0; c < 3 * (MAX_HOLD + TURN_CYC); c++) begin
            @(posedge clk); #1;
            want = (c % (MAX_HOLD + TURN_CYC) < MAX_HOLD) ? 4'b0010 : 4'b0000;
            n_checks++; if (bus.grant !== want || bus.drive_en !== want) begin n_err++; $display("FAIL forced c%0d: got grant=%b drive_en=%b want %b", c, bus.grant, bus.drive_en, want); end
        end
        @(negedge clk) bus.req = '0;
    endtask
    task automatic test_random();
        logic [N-1:0] r;
        logic [N-1:0] last_nz;
        int zeros;
        do_reset();
        r = '0;
        last_nz = '0;
        zeros = 0;
        for (int c = 0; c < 10000; c++) begin
            @(negedge clk);
            for (int b = 0; b < N; b++) if ($urandom_range(0, 5) == 0) r[b] = ~r[b];
            bus.req = r;
            @(posedge clk); #1;
            n_checks++; if (bus.grant !== exp_grant) begin n_err++; $display("FAIL rand grant c%0d: got %b want %b", c, bus.grant, exp_grant); end
            n_checks++; if (bus.drive_en !== exp_drive) begin n_err++; $display("FAIL rand drive_en c%0d: got %b want %b", c, bus.drive_en, exp_drive); end
            n_checks++; if (bus.owner_id !== exp_owner) begin n_err++; $display("FAIL rand owner_id c%0d: got %0d want %0d", c, bus.owner_id, exp_owner); end
            n_checks++; if (bus.bus_busy !== exp_busy) begin n_err++; $display("FAIL rand bus_busy c%0d: got %b want %b", c, bus.bus_busy, exp_busy); end
            n_checks++; if ($countones(bus.drive_en) > 1) begin n_err++; $display("FAIL rand contention c%0d: drive_en=%b want at most one bit", c, bus.drive_en); end
            if (bus.drive_en != '0) begin
                if (last_nz != '0 && bus.drive_en != last_nz) begin
                    n_checks++; if (zeros < TURN_CYC) begin n_err++; $display("FAIL rand gap c%0d: got %0d idle cycles want >=%0d", c, zeros, TURN_CYC); end
                end
                last_nz = bus.drive_en;
                zeros = 0;
            end else zeros++;
        end
        @(negedge clk) bus.req = '0;
    endtask
`ifdef TSB_PARK_EN
    task automatic test_park();
        do_reset();
        @(negedge clk) bus.req = 4'b0100;
        repeat (2) @(posedge clk);
        @(negedge clk) bus.req = '0;
        repeat (2) @(posedge clk);
        #1;
        n_checks++; if (bus.drive_en !== 4'b0100 || bus.grant !== 4'b0000 || bus.bus_busy !== 1'b0) begin n_err++; $display("FAIL park idle: got drive_en=%b grant=%b busy=%b want 0100/0000/0", bus.drive_en, bus.grant, bus.bus_busy); end
        @(negedge clk) bus.req = 4'b0100;
        @(posedge clk); #1;
        n_checks++; if (bus.grant !== 4'b0100 || bus.drive_en !== 4'b0100) begin n_err++; $display("FAIL park direct: got grant=%b drive_en=%b want 0100", bus.grant, bus.drive_en); end
        @(negedge clk) bus.req = '0;
        repeat (2) @(posedge clk);
        @(negedge clk) bus.req = 4'b0001;
        @(posedge clk); #1;
        n_checks++; if (bus.drive_en !== 4'b0000 || bus.bus_busy !== 1'b1) begin n_err++; $display("FAIL park turn: got drive_en=%b busy=%b want 0000/1", bus.drive_en, bus.bus_busy); end
        @(posedge clk); #1;
        n_checks++; if (bus.grant !== 4'b0001 || bus.drive_en !== 4'b0001) begin n_err++; $display("FAIL park handover: got grant=%b drive_en=%b want 0001", bus.grant, bus.drive_en); end
        @(negedge clk) bus.req = '0;
    endtask
`endif
    initial begin
        bus.req = '0;
        test_reset();
        test_reset_in_own();
        test_single();
        test_simultaneous();
        test_forced_release();
`ifdef TSB_PARK_EN
        test_park();
`endif
        test_random();
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end
endmodule
